mem_store_queue: RTL

//  Store path between execute stage and DMEM/IMEM. Buffers store requests in a DEPTH-entry FIFO, forms byte masks and

---
 rtl/mem_store_queue.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_store_queue.sv
// Store queue between execute and memory: buffers stores, builds lane-shifted beats with byte masks,
// splits word-crossing stores into two aligned beats and flags stores that must be dropped.
module mem_store_queue #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter int DEPTH            = 4,
  parameter int SPLIT_MISALIGNED = 1,
  parameter int DMEM_SEL_BIT     = 28,
  parameter int IMEM_SEL_BIT     = 29
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_dmem_we,
  output logic                mem_imem_we,
  output logic                err_valid,
  output logic [1:0]          err_code,
  output logic                empty
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1} state_t;

  logic [2:0]        fifo_f3_q   [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, b1_addr_q, b1_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, b1_wdata_q, b1_wdata_d;
  logic [BYTES-1:0]  mem_wmask_q, mem_wmask_d, b1_wmask_q, b1_wmask_d;
  logic              split_q, split_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [2:0]          head_f3;
  logic [ADDR_W-1:0]   head_addr, beat0_addr, beat1_addr;
  logic [DATA_W-1:0]   head_data, data_masked;
  logic [BYTES-1:0]    size_mask;
  logic [OFF_W-1:0]    off;
  logic [2*BYTES-1:0]  full_mask;
  logic [2*DATA_W-1:0] full_data;
  logic                legal, split, push, pop, load_head, last_done;
  logic [1:0]          drop_code;

  assign req_ready = (count_q != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;

  // Decode the FIFO head into its two candidate beats and its drop reason (00 = issue it).
  always_comb begin
    head_f3   = fifo_f3_q[rd_ptr_q];
    head_addr = fifo_addr_q[rd_ptr_q];
    head_data = fifo_data_q[rd_ptr_q];
    size_mask = '0;
    legal     = 1'b1;
    case (head_f3)
      3'b000:  size_mask[0]   = 1'b1;
      3'b001:  size_mask[1:0] = 2'b11;
      3'b010:  size_mask[3:0] = 4'hF;
      3'b011:  if (DATA_W == 64) size_mask = '1; else legal = 1'b0;
      default: legal = 1'b0;
    endcase
    data_masked = '0;
    for (int b = 0; b < BYTES; b++)
      data_masked[8*b +: 8] = size_mask[b] ? head_data[8*b +: 8] : 8'h00;
    off        = head_addr[OFF_W-1:0];
    full_mask  = {{BYTES{1'b0}}, size_mask} << off;
    full_data  = {{DATA_W{1'b0}}, data_masked} << {off, 3'b000};
    beat0_addr = {head_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    beat1_addr = beat0_addr + ADDR_W'(BYTES);
    split      = |full_mask[2*BYTES-1:BYTES];
    if (!legal)
      drop_code = 2'b01;
    else if (split && (SPLIT_MISALIGNED == 0))
      drop_code = 2'b10;
    else if (!beat0_addr[DMEM_SEL_BIT] && !beat0_addr[IMEM_SEL_BIT])
      drop_code = 2'b11;
    else
      drop_code = 2'b00;
  end

  // Next-state logic: the last handshake of a store may immediately load the next head.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    b1_addr_d   = b1_addr_q;
    b1_wdata_d  = b1_wdata_q;
    b1_wmask_d  = b1_wmask_q;
    split_d     = split_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    load_head   = 1'b0;
    last_done   = 1'b0;
    case (state_q)
      IDLE:    load_head = (count_q != '0);
      ISSUE0:  if (mem_ready) begin
                 if (split_q) begin
                   mem_addr_d  = b1_addr_q;
                   mem_wdata_d = b1_wdata_q;
                   mem_wmask_d = b1_wmask_q;
                   state_d     = ISSUE1;
                 end else begin
                   last_done = 1'b1;
                 end
               end
      ISSUE1:  last_done = mem_ready;
      default: state_d = IDLE;
    endcase
    if (last_done) begin
      if (count_q != '0) begin
        load_head = 1'b1;
      end else begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    end
    if (load_head) begin
      if (drop_code != 2'b00) begin
        err_valid_d = 1'b1;
        err_code_d  = drop_code;
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end else begin
        mem_addr_d  = beat0_addr;
        mem_wdata_d = full_data[DATA_W-1:0];
        mem_wmask_d = full_mask[BYTES-1:0];
        b1_addr_d   = beat1_addr;
        b1_wdata_d  = full_data[2*DATA_W-1:DATA_W];
        b1_wmask_d  = full_mask[2*BYTES-1:BYTES];
        split_d     = split;
        mem_valid_d = 1'b1;
        state_d     = ISSUE0;
      end
    end
    pop      = load_head;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_f3_q[wr_ptr_q]   <= req_funct3;
      fifo_addr_q[wr_ptr_q] <= req_addr;
      fifo_data_q[wr_ptr_q] <= req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      b1_addr_q   <= '0;
      b1_wdata_q  <= '0;
      b1_wmask_q  <= '0;
      split_q     <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      b1_addr_q   <= b1_addr_d;
      b1_wdata_q  <= b1_wdata_d;
      b1_wmask_q  <= b1_wmask_d;
      split_q     <= split_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_valid   = mem_valid_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_dmem_we = mem_addr_q[DMEM_SEL_BIT];
  assign mem_imem_we = mem_addr_q[IMEM_SEL_BIT];
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign empty       = (count_q == '0) && (state_q == IDLE);

endmodule
